// File: rtl/seq_cla_wide_adder_pkg.sv
// Shared FSM encoding, default geometry and counter-width helpers for seq_cla_wide_adder.
`ifndef SEQ_CLA_WIDE_ADDER_PKG_SV
`define SEQ_CLA_WIDE_ADDER_PKG_SV

`define SEQ_CLA_CNT_W(n) (((n) > 1) ? $clog2(n) : 1)

package seq_cla_wide_adder_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ADD  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    localparam int DEF_BLOCK = 4;

    // A counter that must reach n-1 still needs at least one bit when n == 1.
    function automatic int cnt_w(input int n);
        return `SEQ_CLA_CNT_W(n);
    endfunction

endpackage

`endif

// File: rtl/seq_cla_wide_adder_cla_block.sv
// Combinational carry-look-ahead block: every internal carry is a flat
// generate/propagate sum of products rather than a ripple chain.
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             g,
    output logic             p
);

    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK:0]   c;

    assign gen  = a & b;
    assign prop = a ^ b;

    // c[i] = cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1], expanded per carry.
    always_comb begin
        logic term;
        c    = '0;
        g    = 1'b0;
        term = 1'b0;
        for (int i = 0; i <= BLOCK; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) term = term & prop[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k < i; k++) term = term & prop[k];
                c[i] = c[i] | term;
            end
        end
        for (int j = 0; j < BLOCK; j++) begin
            term = gen[j];
            for (int k = j + 1; k < BLOCK; k++) term = term & prop[k];
            g = g | term;
        end
    end

    assign p    = &prop;
    assign s    = prop ^ c[BLOCK-1:0];
    assign cout = c[BLOCK];

endmodule

// File: rtl/seq_cla_wide_adder.sv
// Pin-limited multi-cycle adder: CHUNK-bit beats in, one BLOCK-bit CLA step per cycle,
// CHUNK-bit beats out. Define SEQ_CLA_SUB_EN to enable the op_sub subtract mode.
module seq_cla_wide_adder
    import seq_cla_wide_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CHUNK-1:0] in_data,
    output logic             in_ready,
    input  logic             op_sub,
    output logic             out_valid,
    output logic [CHUNK-1:0] out_data,
    output logic             out_last,
    output logic             out_carry,
    input  logic             out_ready
);

    localparam int NC   = WIDTH / CHUNK;
    localparam int NB   = WIDTH / BLOCK;
    localparam int MAXC = (2 * NC > NB) ? 2 * NC : NB;
    localparam int CW   = cnt_w(MAXC);

    localparam logic [CW-1:0]    NC_CNT   = CW'(NC);
    localparam logic [CW-1:0]    LAST_IN  = CW'(2 * NC - 1);
    localparam logic [CW-1:0]    LAST_BLK = CW'(NB - 1);
    localparam logic [CW-1:0]    LAST_OUT = CW'(NC - 1);
    localparam logic [WIDTH-1:0] CH_MASK  = WIDTH'({CHUNK{1'b1}});
    localparam logic [WIDTH-1:0] BLK_MASK = WIDTH'({BLOCK{1'b1}});

    if ((WIDTH % CHUNK) != 0 || (WIDTH % BLOCK) != 0) begin : g_bad_params
        $fatal(1, "seq_cla_wide_adder: WIDTH must be a multiple of CHUNK and BLOCK");
    end

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic             sub;
    int               in_pos, blk_pos, out_pos;
    logic [BLOCK-1:0] a_blk, b_blk, s_blk;
    logic             blk_cout, unused_g, unused_p;

`ifdef SEQ_CLA_SUB_EN
    logic sub_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sub_reg <= 1'b0;
        else if (state == ST_LOAD && in_valid && cnt == '0)
            sub_reg <= op_sub;
    end

    assign sub = sub_reg;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign sub = 1'b0;
`endif

    // One counter serves as load beat index, ADD block index and output beat index.
    assign in_pos  = (cnt < NC_CNT) ? int'(cnt) * CHUNK : int'(cnt - NC_CNT) * CHUNK;
    assign blk_pos = int'(cnt) * BLOCK;
    assign out_pos = int'(cnt) * CHUNK;

    assign a_blk = BLOCK'(a_reg >> blk_pos);
    assign b_blk = BLOCK'(b_reg >> blk_pos) ^ {BLOCK{sub}};

    cla_block #(.BLOCK(BLOCK)) u_cla (
        .a    (a_blk),
        .b    (b_blk),
        .cin  (carry_reg),
        .s    (s_blk),
        .cout (blk_cout),
        .g    (unused_g),
        .p    (unused_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_carry  = 1'b0;
        out_data   = '0;
        unique case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt == LAST_IN) begin
                        state_next = ST_ADD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_ADD: begin
                if (cnt == LAST_BLK) begin
                    state_next = ST_OUT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_data  = CHUNK'(sum_reg >> out_pos);
                out_last  = (cnt == LAST_OUT);
                out_carry = carry_reg;
                if (out_ready) begin
                    if (cnt == LAST_OUT) begin
                        state_next = ST_LOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_LOAD;
                cnt_next   = '0;
            end
        endcase
    end

    // Operands keep their value after a transaction; only the addressed slice changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (cnt < NC_CNT)
                            a_reg <= (a_reg & ~(CH_MASK << in_pos)) | (WIDTH'(in_data) << in_pos);
                        else
                            b_reg <= (b_reg & ~(CH_MASK << in_pos)) | (WIDTH'(in_data) << in_pos);
                        if (cnt == LAST_IN)
                            carry_reg <= sub;
                    end
                end
                ST_ADD: begin
                    sum_reg   <= (sum_reg & ~(BLK_MASK << blk_pos)) | (WIDTH'(s_blk) << blk_pos);
                    carry_reg <= blk_cout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cla_wide_adder.sv
// Randomised self-checking bench for seq_cla_wide_adder against a plain-arithmetic sum model.
module tb_seq_cla_wide_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int BLOCK = 4;
    localparam int NC    = WIDTH / CHUNK;
    localparam int NB    = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [CHUNK-1:0] in_data;
    logic             in_ready;
    logic             op_sub;
    logic             out_valid;
    logic [CHUNK-1:0] out_data;
    logic             out_last;
    logic             out_carry;
    logic             out_ready;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    seq_cla_wide_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_carry (out_carry),
        .out_ready (out_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Reference: (A + B' + cin) with the carry in bit WIDTH.
    function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sub);
        logic sub_on;
`ifdef SEQ_CLA_SUB_EN
        sub_on = sub;
`else
        sub_on = 1'b0 & sub;
`endif
        if (sub_on)
            return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else
            return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [WIDTH-1:0] randWord();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < WIDTH; k += 16)
            w = (w << 16) | WIDTH'($urandom_range(0, 65535));
        return w;
    endfunction

    task automatic applyReset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput({tag, "_in_ready"},  in_ready,  1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_last"},  out_last,  0);
        checkOutput({tag, "_out_carry"}, out_carry, 0);
        checkOutput({tag, "_out_data"},  out_data,  0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // stop_beats >= 0 abandons the transaction after that many accepted beats
    // (2*NC lands in ADD); stop_at_out abandons it at the first output beat.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                                 input bit gaps, input bit stalls, input int stop_beats, input bit stop_at_out);
        logic [WIDTH:0]     expect_sum;
        logic [2*WIDTH-1:0] operands;
        int k, budget, lat, j, held;
        expect_sum = refSum(a, b, sub);
        operands   = {b, a};
        k = 0;
        budget = 0;
        while (k < 2 * NC && k != stop_beats && budget < 1000) begin
            @(negedge clk);
            budget++;
            if (gaps && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = operands[k*CHUNK +: CHUNK];
                op_sub   = sub;
            end
            if (in_valid && in_ready) k++;
        end
        if (budget >= 1000) begin
            checkOutput("load_timeout", k, 2 * NC);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (k == stop_beats) return;
        checkOutput("in_ready_add", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 4 * NB + 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("add_latency", lat, NB);
        if (!out_valid || stop_at_out) return;
        j = 0;
        held = 0;
        budget = 0;
        while (j < NC && budget < 1000) begin
            budget++;
            out_ready = 1'b1;
            if (stalls) begin
                if (j == NC / 2 && held < 3) begin
                    out_ready = 1'b0;
                    held++;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            checkOutput($sformatf("out_data[%0d]", j), out_data, expect_sum[j*CHUNK +: CHUNK]);
            checkOutput("out_last", out_last, (j == NC - 1));
            checkOutput("out_carry", out_carry, expect_sum[WIDTH]);
            checkOutput("out_valid", out_valid, 1);
            checkOutput("in_ready_out", in_ready, 0);
            if (out_ready) j++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        checkOutput("out_beats", j, NC);
        checkOutput("in_ready_after", in_ready, 1);
        checkOutput("out_valid_after", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_data = '0;
        op_sub  = 1'b0;
        applyReset("por");

        applyStimulus(WIDTH'(16'h1234), WIDTH'(16'h4321), 1'b0, 1'b0, 1'b0, -1, 1'b0);
        applyStimulus('1, WIDTH'(1), 1'b0, 1'b0, 1'b0, -1, 1'b0);
        applyStimulus(WIDTH'(16'h1234), WIDTH'(16'h4321), 1'b0, 1'b1, 1'b1, -1, 1'b0);

        applyStimulus(randWord(), randWord(), 1'b0, 1'b0, 1'b0, (2 * NC - 1 < 5) ? 2 * NC - 1 : 5, 1'b0);
        #2;
        applyReset("rst_load");
        applyStimulus(WIDTH'(3), WIDTH'(4), 1'b0, 1'b0, 1'b0, -1, 1'b0);

        applyStimulus(WIDTH'(5), WIDTH'(7), 1'b1, 1'b0, 1'b0, -1, 1'b0);

        applyStimulus(randWord(), randWord(), 1'b0, 1'b0, 1'b0, 2 * NC, 1'b0);
        #2;
        applyReset("rst_add");
        applyStimulus(randWord(), randWord(), 1'b0, 1'b0, 1'b0, -1, 1'b1);
        #2;
        applyReset("rst_out");
        applyStimulus(WIDTH'(16'h00F0), WIDTH'(16'h0F10), 1'b0, 1'b0, 1'b0, -1, 1'b0);

        for (int n = 0; n < 200; n++)
            applyStimulus(randWord(), randWord(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/seq_cla_wide_adder.md
Name: seq_cla_wide_adder

Overview:
- Multi-cycle, pin-limited adder. Wide operands A and B are loaded as CHUNK-bit beats on one narrow bus.
- The sum is computed one BLOCK-bit carry-look-ahead block per cycle, with block carries chained through a register.
- The result is streamed back out in CHUNK-bit beats.
- Successor to the single-cycle pin-muxed CLA top: wider operands, explicit handshakes, an FSM, and an optional subtract mode.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of both CHUNK and BLOCK.
- CHUNK, 4, input/output beat width in bits.
- BLOCK, 4, bits resolved per ADD cycle by the CLA block.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data holds a valid beat.
- in_data  input  CHUNK  operand beat, least-significant chunk first; all A beats, then all B beats.
- in_ready  output  1  block accepts a beat this cycle.
- op_sub  input  1  subtract request; sampled with the first A beat; see Optional Feature.
- out_valid  output  1  out_data holds a valid sum beat.
- out_data  output  CHUNK  sum beat, least-significant chunk first.
- out_last  output  1  current beat is the final (most-significant) sum chunk.
- out_carry  output  1  carry-out of the MSB; stable for the whole OUT phase.
- out_ready  input  1  consumer accepts the current beat.

Behaviour:
- Definitions: NC = WIDTH/CHUNK; NB = WIDTH/BLOCK.
- Reset (async assert, released synchronously to clk):
  - state = LOAD; beat counter = 0.
  - A, B, sum registers = 0; carry register = 0.
  - in_ready = 1; out_valid = 0; out_last = 0; out_carry = 0; out_data = 0.
- State LOAD:
  - in_ready = 1. A beat is accepted on a rising edge where in_valid && in_ready.
  - Beat k (0..NC-1) is written to A[k*CHUNK +: CHUNK].
  - Beat NC+k is written to B[k*CHUNK +: CHUNK].
  - in_valid low holds the state with no change.
  - The edge that accepts beat 2*NC-1 moves to ADD: block index = 0, carry register = cin.
- State ADD:
  - in_ready = 0.
  - Each cycle, block i computes S[i] and the carry-out from A[i], B'[i] and the carry register, using generate/propagate look-ahead (no intra-block ripple).
  - S[i] and the carry are registered; i increments.
  - After NB ADD cycles, move to OUT. out_valid first rises exactly NB edges after the last B beat was accepted.
- State OUT:
  - out_valid = 1; out_data = sum chunk j; out_last = (j == NC-1); out_carry = final carry.
  - j advances only on edges where out_ready = 1. out_ready low holds out_data stable.
  - Acceptance of the last beat returns to LOAD: counters cleared; A and B keep their values until overwritten.
  - in_ready rises in the cycle after the last output beat is accepted. Input beats are never accepted in OUT.
- Arithmetic: sum = (A + B' + cin) mod 2^WIDTH; out_carry = bit WIDTH of that sum. Without subtract, B' = B and cin = 0.
- Boundary rules:
  - Asserting rst mid-LOAD, mid-ADD or mid-OUT discards the transaction immediately.
  - WIDTH == BLOCK is legal: ADD lasts 1 cycle.
  - CHUNK == WIDTH is legal: one beat per operand.
  - Illegal parameter ratios are caught by an elaboration-time check that stops the build.

Optional Feature:
- Macro: SEQ_CLA_SUB_EN.
- Defined:
  - op_sub is latched on acceptance of beat 0 and held for the transaction.
  - When set, B' = ~B and cin = 1, giving A - B.
  - out_carry = 1 means no borrow (A >= B unsigned).
- Undefined:
  - op_sub is still a port but is ignored; B' = B, cin = 0.
  - No latch register is synthesised.

Decomposition:
- Shared package/header (global.vh style) holds:
  - the FSM state encodings ST_LOAD, ST_ADD, ST_OUT (2-bit);
  - the default WIDTH/CHUNK/BLOCK constants;
  - a clog2-based macro for the counter widths.
- Natural sub-module: cla_block #(BLOCK). It is purely combinational: inputs a, b, cin; outputs s, cout, plus group g/p.
- The top-level FSM, operand registers and counters live in seq_cla_wide_adder.

Test Plan:
- Basic add: load A = 0x1234, B = 0x4321 (beats 4,3,2,1 then 1,2,3,4), out_ready held 1 -> out_valid after 4 edges; beats 5,5,5,5; out_carry = 0; out_last on beat 4.
- Full carry chain: A = 0xFFFF, B = 0x0001 -> sum 0x0000, out_carry = 1. Checks carry across all 4 blocks.
- Backpressure: in_valid toggled 1/0 during LOAD, out_ready low for 3 cycles mid-OUT -> no beat lost or duplicated, out_data stable while stalled, same 0x5555 result.
- Reset mid-transaction: assert rst after 5 of 8 input beats -> outputs return to reset values asynchronously. A fresh 0x0003 + 0x0004 then yields 0x0007.
- Subtract (SEQ_CLA_SUB_EN defined): op_sub = 1, A = 0x0005, B = 0x0007 -> 0xFFFE, out_carry = 0. Macro undefined with the same stimulus -> 0x000C, out_carry = 0.
- Parameter sweep: WIDTH=8/CHUNK=8/BLOCK=8 and WIDTH=32/CHUNK=4/BLOCK=8 -> 200 random vectors each match the reference model; ADD latency is 1 and 4 cycles respectively.
